// File: rtl/alu_pkg.sv
// Shared opcode/state definitions and opcode classification helpers for alu_iter.
package alu_pkg;

   typedef enum logic [4:0] {
      OP_AND    = 5'b00000,
      OP_OR     = 5'b00001,
      OP_ADD    = 5'b00010,
      OP_XOR    = 5'b00011,
      OP_SLL    = 5'b00100,
      OP_SRL    = 5'b00101,
      OP_SUB    = 5'b00110,
      OP_SRA    = 5'b00111,
      OP_EQ     = 5'b01000,
      OP_SLT    = 5'b01100,
      OP_SLTU   = 5'b01101,
      OP_MUL    = 5'b10000,
      OP_MULH   = 5'b10001,
      OP_MULHSU = 5'b10010,
      OP_MULHU  = 5'b10011,
      OP_DIV    = 5'b10100,
      OP_DIVU   = 5'b10101,
      OP_REM    = 5'b10110,
      OP_REMU   = 5'b10111
   } alu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_MUL  = 2'b01,
      ST_DIV  = 2'b10,
      ST_DONE = 2'b11
   } alu_state_e;

   // Multiply/divide group occupies 10xxx; 11xxx is undefined (single-cycle, result 0).
   function automatic logic is_multicycle(input logic [4:0] op);
      return op[4:3] == 2'b10;
   endfunction

   function automatic logic is_divide(input logic [4:0] op);
      return (op[4:3] == 2'b10) && op[2];
   endfunction

   function automatic logic is_signed_a(input logic [4:0] op);
      return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
   endfunction

   function automatic logic is_signed_b(input logic [4:0] op);
      return op inside {OP_MULH, OP_DIV, OP_REM};
   endfunction

endpackage

// File: rtl/mul_div_iter.sv
// Iterative RV32M engine: shift-add multiply / restoring divide on magnitudes,
// one bit per cycle, followed by one sign / special-case fixup cycle.
module mul_div_iter
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [4:0]            op,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] result
);

   localparam int W  = DATA_WIDTH;
   localparam int CW = $clog2(W) + 1;
   localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

   // p holds {acc, multiplier} for multiply and {remainder, quotient} for divide
   logic [2*W-1:0] p;
   logic [2*W-1:0] p_next;
   logic [W-1:0]   m;        // multiplicand magnitude (MUL) or divisor magnitude (DIV)
   logic [W-1:0]   a_orig;
   logic [CW-1:0]  count;
   logic           active;
   logic           div_mode;
   logic           sel_alt;  // high half for MULH*, remainder for REM*
   logic           neg_res;
   logic           neg_rem;
   logic           div0;
   logic           ovf;

   logic           sa, sb;
   logic [W-1:0]   mag_a, mag_b;
   logic [W-1:0]   mul_addend;
   logic [W:0]     mul_sum;
   logic [W+1:0]   div_diff;
   logic [2*W-1:0] prod;
   logic [W-1:0]   q_s, r_s;

   // Operand signs and magnitudes seen at start
   always_comb begin
      sa    = is_signed_a(op) & a[W-1];
      sb    = is_signed_b(op) & b[W-1];
      mag_a = sa ? -a : a;
      mag_b = sb ? -b : b;
   end

   // One multiply or divide step
   always_comb begin
      mul_addend = p[0] ? m : '0;
      mul_sum    = {1'b0, p[2*W-1:W]} + {1'b0, mul_addend};
      div_diff   = {1'b0, p[2*W-1:W], p[W-1]} - {2'b00, m};
      if (div_mode) begin
         if (!div_diff[W+1]) p_next = {div_diff[W-1:0], p[W-2:0], 1'b1};
         else                p_next = {p[2*W-2:0], 1'b0};
      end else begin
         p_next = {mul_sum, p[W-1:1]};
      end
   end

   // Sign fixup and divide special cases applied to the finished magnitudes
   always_comb begin
      prod = neg_res ? -p : p;
      q_s  = neg_res ? -p[W-1:0] : p[W-1:0];
      r_s  = neg_rem ? -p[2*W-1:W] : p[2*W-1:W];
      if (div0) begin
         q_s = '1;
         r_s = a_orig;
      end else if (ovf) begin
         q_s = MOST_NEG;
         r_s = '0;
      end
      if (div_mode) result = sel_alt ? r_s : q_s;
      else          result = sel_alt ? prod[2*W-1:W] : prod[W-1:0];
      done = active && (count == CW'(W));
   end

   // Operand capture, iteration counter and datapath registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         p        <= '0;
         m        <= '0;
         a_orig   <= '0;
         count    <= '0;
         active   <= 1'b0;
         div_mode <= 1'b0;
         sel_alt  <= 1'b0;
         neg_res  <= 1'b0;
         neg_rem  <= 1'b0;
         div0     <= 1'b0;
         ovf      <= 1'b0;
      end else if (start) begin
         div_mode <= is_divide(op);
         sel_alt  <= is_divide(op) ? op[1] : (op[1:0] != 2'b00);
         neg_res  <= sa ^ sb;
         neg_rem  <= sa;
         div0     <= (b == '0);
         ovf      <= is_signed_a(op) && (a == MOST_NEG) && (b == '1);
         a_orig   <= a;
         count    <= '0;
         active   <= 1'b1;
         if (is_divide(op)) begin
            p <= {{W{1'b0}}, mag_a};
            m <= mag_b;
         end else begin
            p <= {{W{1'b0}}, mag_b};
            m <= mag_a;
         end
      end else if (active) begin
         if (count == CW'(W)) begin
            active <= 1'b0;
         end else begin
            p     <= p_next;
            count <= count + 1'b1;
         end
      end
   end

endmodule

// File: rtl/alu_iter.sv
// Handshaked RV32I/RV32M ALU: single-cycle ops registered on accept,
// multiply/divide delegated to the iterative engine.
module alu_iter
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH    = 32,
   parameter int OPCODE_LENGTH = 5
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [OPCODE_LENGTH-1:0] Operation,
   input  logic [DATA_WIDTH-1:0]    SrcA,
   input  logic [DATA_WIDTH-1:0]    SrcB,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DATA_WIDTH-1:0]    ALUResult
);

   localparam int SHW = $clog2(DATA_WIDTH);

   alu_state_e            state, state_next;
   logic [4:0]            op;
   logic [SHW-1:0]        shamt;
   logic [DATA_WIDTH-1:0] sc_result;
   logic                  accept;
   logic                  start;
   logic                  eng_done;
   logic [DATA_WIDTH-1:0] eng_result;

   // Single-cycle datapath
   always_comb begin
      op    = 5'(Operation);
      shamt = SrcB[SHW-1:0];
      case (op)
         OP_AND:  sc_result = SrcA & SrcB;
         OP_OR:   sc_result = SrcA | SrcB;
         OP_ADD:  sc_result = SrcA + SrcB;
         OP_XOR:  sc_result = SrcA ^ SrcB;
         OP_SLL:  sc_result = SrcA << shamt;
         OP_SRL:  sc_result = SrcA >> shamt;
         OP_SUB:  sc_result = SrcA - SrcB;
         OP_SRA:  sc_result = DATA_WIDTH'($signed(SrcA) >>> shamt);
         OP_EQ:   sc_result = DATA_WIDTH'(SrcA == SrcB);
         OP_SLT:  sc_result = DATA_WIDTH'($signed(SrcA) < $signed(SrcB));
         OP_SLTU: sc_result = DATA_WIDTH'(SrcA < SrcB);
         default: sc_result = '0;
      endcase
   end

   // Handshake decode and next-state logic
   always_comb begin
      in_ready   = (state == ST_IDLE);
      out_valid  = (state == ST_DONE);
      accept     = in_valid && in_ready;
      start      = accept && is_multicycle(op);
      state_next = state;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               if (!is_multicycle(op)) state_next = ST_DONE;
               else if (is_divide(op)) state_next = ST_DIV;
               else                    state_next = ST_MUL;
            end
         end
         ST_MUL, ST_DIV: if (eng_done) state_next = ST_DONE;
         ST_DONE:        if (out_ready) state_next = ST_IDLE;
         default:        state_next = ST_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_next;
   end

   // Result register: loaded on single-cycle accept or on engine completion
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ALUResult <= '0;
      end else if (accept && !is_multicycle(op)) begin
         ALUResult <= sc_result;
      end else if ((state == ST_MUL || state == ST_DIV) && eng_done) begin
         ALUResult <= eng_result;
      end
   end

   mul_div_iter #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_mul_div (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .op    (op),
      .a     (SrcA),
      .b     (SrcB),
      .done  (eng_done),
      .result(eng_result)
   );

endmodule

// File: tb/tb_alu_iter.sv
// Directed testbench for alu_iter with hand-computed expected values.
module tb_alu_iter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [4:0]  Operation = '0;
   logic [31:0] SrcA = '0;
   logic [31:0] SrcB = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] ALUResult;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_iter #(
      .DATA_WIDTH(32),
      .OPCODE_LENGTH(5)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .Operation(Operation),
      .SrcA     (SrcA),
      .SrcB     (SrcB),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .ALUResult(ALUResult)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // Issue one op, count edges after the accept edge until out_valid, then consume.
   task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int edges);
      int n;
      @(negedge clk);
      check({tag, "/in_ready"}, 32'(in_ready), 32'd1);
      Operation = op;
      SrcA      = a;
      SrcB      = b;
      in_valid  = 1'b1;
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      Operation = 5'($urandom);
      SrcA      = $urandom;
      SrcB      = $urandom;
      n = 0;
      while (out_valid !== 1'b1 && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      check({tag, "/latency"}, 32'(n), 32'(edges));
      check({tag, "/result"}, ALUResult, exp);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check({tag, "/idle"}, {30'd0, out_valid, in_ready}, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      // Reset state
      #12;
      check("reset/out_valid", 32'(out_valid), 32'd0);
      check("reset/in_ready", 32'(in_ready), 32'd1);
      check("reset/result", ALUResult, 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // Single-cycle ops
      run_op("add_ovf", 5'b00010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 0);
      run_op("sra36",   5'b00111, 32'h80000000, 32'd36,       32'hF8000000, 0);
      run_op("sll31",   5'b00100, 32'h00000001, 32'd31,       32'h80000000, 0);
      run_op("srl4",    5'b00101, 32'h80000000, 32'd4,        32'h08000000, 0);
      run_op("sub",     5'b00110, 32'd3,        32'd5,        32'hFFFFFFFE, 0);
      run_op("xor",     5'b00011, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 0);
      run_op("and",     5'b00000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 0);
      run_op("or",      5'b00001, 32'hF0F0F0F0, 32'h0F000000, 32'hFFF0F0F0, 0);
      run_op("slt",     5'b01100, 32'hFFFFFFFF, 32'd1,        32'd1,        0);
      run_op("sltu",    5'b01101, 32'hFFFFFFFF, 32'd1,        32'd0,        0);
      run_op("eq",      5'b01000, 32'd5,        32'd5,        32'd1,        0);
      run_op("undef",   5'b11111, 32'd5,        32'd5,        32'd0,        0);

      // Multiply
      run_op("mul",     5'b10000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 33);
      run_op("mulh",    5'b10001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33);
      run_op("mulhu",   5'b10011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
      run_op("mulhsu",  5'b10010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33);
      run_op("mul_neg", 5'b10000, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1, 33);
      run_op("mulh_neg",5'b10001, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 33);

      // Divide
      run_op("div",     5'b10100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
      run_op("rem",     5'b10110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
      run_op("divu0",   5'b10101, 32'd7,        32'd0,        32'hFFFFFFFF, 33);
      run_op("remu0",   5'b10111, 32'd7,        32'd0,        32'd7,        33);
      run_op("div0s",   5'b10100, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, 33);
      run_op("rem0s",   5'b10110, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 33);
      run_op("div_ovf", 5'b10100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33);
      run_op("rem_ovf", 5'b10110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 33);
      run_op("divu",    5'b10101, 32'd100,      32'd7,        32'd14,       33);
      run_op("remu",    5'b10111, 32'd100,      32'd7,        32'd2,        33);

      // Back-pressure: MUL 3*5 held for 5 cycles, with a request pulse while busy
      @(negedge clk);
      Operation = 5'b10000;
      SrcA      = 32'd3;
      SrcB      = 32'd5;
      in_valid  = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      n = 0;
      while (out_valid !== 1'b1 && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("bp/latency", 32'(n), 32'd33);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         in_valid  = (i == 2);
         Operation = 5'b00010;
         SrcA      = 32'd100;
         SrcB      = 32'd1;
         @(posedge clk);
         #1;
         check("bp/result_held", ALUResult, 32'd15);
         check("bp/valid_ready", {30'd0, out_valid, in_ready}, 32'd2);
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("bp/release", {30'd0, out_valid, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      check("bp/no_phantom", {30'd0, out_valid, in_ready}, 32'd1);
      check("bp/result_kept", ALUResult, 32'd15);

      // Reset in the middle of DIVU(100, 7)
      @(negedge clk);
      Operation = 5'b10101;
      SrcA      = 32'd100;
      SrcB      = 32'd7;
      in_valid  = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check("rst/busy", {30'd0, out_valid, in_ready}, 32'd0);
      check("rst/before", ALUResult, 32'd15);
      #1;
      reset = 1'b1;
      #1;
      check("rst/out_valid", 32'(out_valid), 32'd0);
      check("rst/result", ALUResult, 32'd0);
      check("rst/in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      reset = 1'b0;
      run_op("post_rst_add", 5'b00010, 32'd2, 32'd3, 32'd5, 0);
      run_op("post_rst_divu", 5'b10101, 32'd100, 32'd7, 32'd14, 33);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
